// File: rtl/memory_stage_pkg.sv
// Shared encodings for the memory stage: opcodes, funct3 access sizes, FSM states
// and alignment helpers used by the top and the lane-steering sub-module.
package memory_stage_pkg;

    localparam int OPCODE_WIDTH = 7;

    localparam logic [OPCODE_WIDTH-1:0] OPCODE_LOAD  = 7'b0000011;
    localparam logic [OPCODE_WIDTH-1:0] OPCODE_STORE = 7'b0100011;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } ms_state_t;

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
        case (funct3[1:0])
            2'b01:   return offset[0];
            2'b10:   return offset != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    // Forces the byte offset onto the natural boundary of the access size.
    function automatic logic [1:0] align_offset(input logic [2:0] funct3, input logic [1:0] offset);
        case (funct3[1:0])
            2'b01:   return {offset[1], 1'b0};
            2'b10:   return 2'b00;
            default: return offset;
        endcase
    endfunction

endpackage

// File: rtl/memory_stage_mem_align.sv
// Combinational byte-lane logic: store data replication and byte enables,
// load lane extraction with sign or zero extension.
module mem_align
    import memory_stage_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] load_data,
    output logic [3:0]  sel,
    output logic [31:0] wdata,
    output logic [31:0] load_result
);

    logic [31:0] shifted;

    always_comb begin
        sel   = 4'b1111;
        wdata = store_data;
        case (funct3[1:0])
            2'b00: begin
                sel   = 4'b0001 << offset;
                wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                sel   = 4'b0011 << {offset[1], 1'b0};
                wdata = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    assign shifted = load_data >> {offset, 3'b000};

    always_comb begin
        case (funct3)
            FUNCT3_LB:  load_result = {{24{shifted[7]}}, shifted[7:0]};
            FUNCT3_LH:  load_result = {{16{shifted[15]}}, shifted[15:0]};
            FUNCT3_LBU: load_result = {24'h000000, shifted[7:0]};
            FUNCT3_LHU: load_result = {16'h0000, shifted[15:0]};
            default:    load_result = load_data;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: single outstanding load/store on a req/ack data bus.
// Define MEMORY_MISALIGN_TRAP_EN to trap misaligned accesses instead of masking them.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int DWIDTH   = 32,
    parameter int AWIDTH   = 5,
    parameter int PC_WIDTH = 32
) (
    input  logic                    ms_clk,
    input  logic                    ms_rst,
    input  logic                    ms_i_ce,
    input  logic                    ms_i_stall,
    input  logic                    ms_i_flush,
    input  logic [OPCODE_WIDTH-1:0] ms_i_opcode,
    input  logic [2:0]              ms_i_funct3,
    input  logic [DWIDTH-1:0]       ms_i_data_rd,
    input  logic [DWIDTH-1:0]       ms_i_data_store,
    input  logic [AWIDTH-1:0]       ms_i_addr_rd,
    input  logic                    ms_i_we_reg,
    input  logic [PC_WIDTH-1:0]     ms_i_pc,
    output logic                    ms_o_stall,
    output logic                    ms_o_ce,
    output logic [DWIDTH-1:0]       ms_o_data_rd,
    output logic [AWIDTH-1:0]       ms_o_addr_rd,
    output logic                    ms_o_we_reg,
    output logic [PC_WIDTH-1:0]     ms_o_pc,
    output logic                    ms_o_misaligned,
    output logic                    ms_o_req,
    output logic                    ms_o_we,
    output logic [DWIDTH-1:0]       ms_o_addr,
    output logic [DWIDTH-1:0]       ms_o_wdata,
    output logic [3:0]              ms_o_sel,
    input  logic                    ms_i_ack,
    input  logic [DWIDTH-1:0]       ms_i_rdata
);

    ms_state_t state_q, state_d;

    logic                is_mem, is_store, accept, trap, start, done, retire, kill;
    logic [2:0]          funct3_q;
    logic [1:0]          offset_q, offset_in;
    logic                store_q, flushed_q, ack_seen_q, we_reg_q;
    logic [DWIDTH-1:0]   rdata_q;
    logic [AWIDTH-1:0]   addr_rd_q;
    logic [PC_WIDTH-1:0] pc_q;
    logic [2:0]          align_funct3;
    logic [1:0]          align_offset_sel;
    logic [3:0]          sel_in;
    logic [DWIDTH-1:0]   wdata_in, load_result, load_data;

    assign is_store  = ms_i_opcode == OPCODE_STORE;
    assign is_mem    = (ms_i_opcode == OPCODE_LOAD) || is_store;
    assign accept    = (state_q == ST_IDLE) && ms_i_ce && !ms_i_flush && !ms_i_stall;
`ifdef MEMORY_MISALIGN_TRAP_EN
    assign trap      = is_mem && is_misaligned(ms_i_funct3, ms_i_data_rd[1:0]);
`else
    assign trap      = 1'b0;
`endif
    assign start     = accept && is_mem && !trap;
    // An ack seen while writeback stalls is parked until the result can retire.
    assign done      = (state_q == ST_BUSY) && (ms_i_ack || ack_seen_q);
    assign retire    = done && !ms_i_stall;
    assign kill      = flushed_q || ms_i_flush;
    assign offset_in = align_offset(ms_i_funct3, ms_i_data_rd[1:0]);

    assign ms_o_stall = ((state_q == ST_BUSY) || ms_i_stall) && !ms_rst;

    // Store steering is needed at capture (IDLE), load extraction at retire (BUSY).
    assign align_funct3     = (state_q == ST_BUSY) ? funct3_q : ms_i_funct3;
    assign align_offset_sel = (state_q == ST_BUSY) ? offset_q : offset_in;
    assign load_data        = ms_i_ack ? ms_i_rdata : rdata_q;

    mem_align u_align (
        .funct3      (align_funct3),
        .offset      (align_offset_sel),
        .store_data  (ms_i_data_store),
        .load_data   (load_data),
        .sel         (sel_in),
        .wdata       (wdata_in),
        .load_result (load_result)
    );

    always_ff @(posedge ms_clk or posedge ms_rst) begin
        if (ms_rst) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start)  state_d = ST_BUSY;
            ST_BUSY: if (retire) state_d = ST_IDLE;
            default:             state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ms_clk or posedge ms_rst) begin
        if (ms_rst) begin
            ms_o_req   <= 1'b0;
            ms_o_we    <= 1'b0;
            ms_o_addr  <= '0;
            ms_o_wdata <= '0;
            ms_o_sel   <= '0;
            funct3_q   <= '0;
            offset_q   <= '0;
            store_q    <= 1'b0;
            addr_rd_q  <= '0;
            we_reg_q   <= 1'b0;
            pc_q       <= '0;
            flushed_q  <= 1'b0;
            ack_seen_q <= 1'b0;
            rdata_q    <= '0;
        end else if (start) begin
            ms_o_req   <= 1'b1;
            ms_o_we    <= is_store;
            ms_o_addr  <= {ms_i_data_rd[DWIDTH-1:2], 2'b00};
            ms_o_wdata <= wdata_in;
            ms_o_sel   <= sel_in;
            funct3_q   <= ms_i_funct3;
            offset_q   <= offset_in;
            store_q    <= is_store;
            addr_rd_q  <= ms_i_addr_rd;
            we_reg_q   <= ms_i_we_reg;
            pc_q       <= ms_i_pc;
            flushed_q  <= 1'b0;
            ack_seen_q <= 1'b0;
        end else if (state_q == ST_BUSY) begin
            if (ms_i_ack) begin
                ms_o_req   <= 1'b0;
                ms_o_we    <= 1'b0;
                ack_seen_q <= 1'b1;
                rdata_q    <= ms_i_rdata;
            end
            if (ms_i_flush) flushed_q <= 1'b1;
        end
    end

    always_ff @(posedge ms_clk or posedge ms_rst) begin
        if (ms_rst) begin
            ms_o_ce         <= 1'b0;
            ms_o_data_rd    <= '0;
            ms_o_addr_rd    <= '0;
            ms_o_we_reg     <= 1'b0;
            ms_o_pc         <= '0;
            ms_o_misaligned <= 1'b0;
        end else if (!ms_i_stall) begin
            ms_o_ce         <= 1'b0;
            ms_o_we_reg     <= 1'b0;
            ms_o_misaligned <= 1'b0;
            if (retire) begin
                ms_o_ce      <= !kill;
                ms_o_we_reg  <= !kill && !store_q && we_reg_q;
                ms_o_data_rd <= store_q ? '0 : load_result;
                ms_o_addr_rd <= addr_rd_q;
                ms_o_pc      <= pc_q;
            end else if (accept && !start) begin
                // Non-memory pass-through, or a trapped misaligned access.
                ms_o_ce         <= 1'b1;
                ms_o_we_reg     <= ms_i_we_reg && !trap;
                ms_o_misaligned <= trap;
                ms_o_data_rd    <= ms_i_data_rd;
                ms_o_addr_rd    <= ms_i_addr_rd;
                ms_o_pc         <= ms_i_pc;
            end
        end
    end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 DWIDTH, 32, data and bus address/data width.
REQ-002 AWIDTH, 5, register index width.
REQ-003 PC_WIDTH, 32, program counter width.
REQ-004 ms_clk  in  1  clock, rising edge.
REQ-005 ms_rst  in  1  reset, asynchronous, active-high.
REQ-006 ms_i_ce  in  1  instruction valid from execute.
REQ-007 ms_i_stall  in  1  writeback cannot accept.
REQ-008 ms_i_flush  in  1  kill incoming/in-flight instruction.
REQ-009 ms_i_opcode  in  `OPCODE_WIDTH  instruction class.
REQ-010 ms_i_funct3  in  3  access size/sign.
REQ-011 ms_i_data_rd  in  DWIDTH  ALU result or effective address.
REQ-012 ms_i_data_store  in  DWIDTH  store data (rs2).
REQ-013 ms_i_addr_rd  in  AWIDTH  destination register.
REQ-014 ms_i_we_reg  in  1  register write request.
REQ-015 ms_i_pc  in  PC_WIDTH  instruction PC.
REQ-016 ms_o_stall  out  1  hold execute.
REQ-017 ms_o_ce  out  1  result valid to writeback.
REQ-018 ms_o_data_rd  out  DWIDTH  writeback data.
REQ-019 ms_o_addr_rd  out  AWIDTH  destination register.
REQ-020 ms_o_we_reg  out  1  register write enable.
REQ-021 ms_o_pc  out  PC_WIDTH  instruction PC.
REQ-022 ms_o_misaligned  out  1  misaligned-access exception.
REQ-023 ms_o_req  out  1  data bus request, held until ack.
REQ-024 ms_o_we  out  1  bus write.
REQ-025 ms_o_addr  out  DWIDTH  word-aligned bus address.
REQ-026 ms_o_wdata  out  DWIDTH  lane-steered store data.
REQ-027 ms_o_sel  out  4  byte enables.
REQ-028 ms_i_ack  in  1  bus completion, one cycle.
REQ-029 ms_i_rdata  in  DWIDTH  load data, valid with ack.

Function
REQ-030 FSM IDLE/BUSY; IDLE + ms_i_ce + load/store + !flush + !stall -> capture, BUSY; ms_o_req registered, asserted from first BUSY cycle; ack -> result registered, IDLE; ms_i_ack in IDLE ignored.
REQ-031 Non-memory: registered pass-through, 1-cycle latency, ms_o_data_rd=ms_i_data_rd; load: ms_o_ce pulses the cycle after ack; ms_o_ce is one pulse per retired instruction.
REQ-032 ms_o_stall = BUSY | ms_i_stall (combinational); while ms_i_stall, all output registers hold.
REQ-033 Store: SB sel=0001<<addr[1:0], wdata=byte x4; SH sel=0011<<{addr[1],0}, wdata=half x2; SW sel=1111; ms_o_we_reg=0.
REQ-034 Load: lane from addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW direct; ms_o_addr={addr[31:2],00}.
REQ-035 Flush in IDLE drops input; flush in BUSY (incl. same cycle as ack): bus cycle completes, result discarded (ce=0, we_reg=0).

Reset
REQ-036 ms_rst: state IDLE, every output 0 immediately, incl. ms_o_req mid-transaction; pending ack discarded.

Configuration
REQ-037 MEMORY_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 -> no bus request, 1-cycle pass-through with ms_o_misaligned=1, ms_o_ce=1, we_reg=0.
REQ-038 Undefined: offending low address bits masked to alignment, access proceeds, ms_o_misaligned tied 0.

Structure
REQ-039 header.vh holds OPCODE_LOAD/OPCODE_STORE, funct3 encodings (LB..SW), FSM state encodings.
REQ-040 One combinational sub-module mem_align: store lane steering/sel, load extraction/extension.

Verification
REQ-041 SW 0xDEADBEEF @0x100, ack after 3 cycles -> req 3 cycles, sel=1111, stall until ack, ce pulse, we_reg=0.
REQ-042 LB @0x103, rdata=0x80000000 -> data_rd=0xFFFFFF80; LBU same -> 0x00000080.
REQ-043 SH 0x1234ABCD @0x202 -> sel=1100, wdata=0xABCDABCD, addr=0x200.
REQ-044 LW @0x102: macro on -> no req, misaligned=1; macro off -> req, addr=0x100.
REQ-045 Flush in BUSY with ack same cycle -> ce stays 0; following ADD result 5 -> data_rd=5 one cycle later.
